// File: rtl/dram_slot_arbiter.sv
// Time-slot DRAM arbiter: 8-clock slots owned by video, CPU or refresh, with strobe sequencing.
// Optional build macro CPU_FAIR_EN: after two video wins with the CPU waiting, the CPU takes a slot.

module dram_slot_arbiter #(
  parameter int unsigned SLOT_LEN    = 8,
  parameter int unsigned REFRESH_DIV = 64,
  parameter int unsigned ROW_BITS    = 7
) (
  input  logic                CLKIN,
  input  logic                RESET,
  input  logic                VID_REQ,
  input  logic [13:0]         VID_ADDR,
  output logic                VID_ACK,
  input  logic                CPU_REQ,
  input  logic                CPU_WR,
  input  logic                CPU_BYTE,
  input  logic [14:0]         CPU_ADDR,
  output logic                CPU_GNT,
  output logic [ROW_BITS-1:0] RA,
  output logic                nRAS,
  output logic [1:0]          nCAS,
  output logic                nWE,
  output logic [1:0]          OWNER
);

  localparam int unsigned ScW  = $clog2(SLOT_LEN);
  localparam int unsigned DivW = $clog2(REFRESH_DIV);

  localparam logic [ScW-1:0]  ScLast   = ScW'(SLOT_LEN - 1);
  localparam logic [ScW-1:0]  PhRow    = ScW'(1);
  localparam logic [ScW-1:0]  PhRasOn  = ScW'(2);
  localparam logic [ScW-1:0]  PhCol    = ScW'(3);
  localparam logic [ScW-1:0]  PhCasOn  = ScW'(4);
  localparam logic [ScW-1:0]  PhLastOn = ScW'(6);
  localparam logic [DivW-1:0] DivLast  = DivW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    OwnIdle = 2'd0,
    OwnVid  = 2'd1,
    OwnCpu  = 2'd2,
    OwnRef  = 2'd3
  } owner_e;

  logic [ScW-1:0]      sc_q, sc_d;
  owner_e              owner_q, owner_d;
  owner_e              winner;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [ROW_BITS-1:0] col_q, col_d;
  logic                wr_q, wr_d;
  logic                byte_q, byte_d;
  logic                lane_q, lane_d;
  logic [ROW_BITS-1:0] ref_row_q, ref_row_d;
  logic [1:0]          pend_q, pend_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                gnt_q, gnt_d;
  logic                live_q, live_d;

  logic [ROW_BITS-1:0] ra_q, ra_d;
  logic                nras_q, nras_d;
  logic [1:0]          ncas_q, ncas_d;
  logic                nwe_q, nwe_d;
  logic                vid_ack_q, vid_ack_d;

  logic boundary;
  logic tick;
  logic serve;
  logic cpu_ok;
  logic data_slot;

`ifdef CPU_FAIR_EN
  logic [1:0] streak_q, streak_d;
`endif

  assign boundary  = (sc_q == ScLast);
  assign tick      = boundary && (div_q == DivLast);
  assign serve     = boundary && (owner_q == OwnRef);
  assign cpu_ok    = CPU_REQ && !gnt_q;
  assign data_slot = (owner_q == OwnVid) || (owner_q == OwnCpu);

  // Pending count after this boundary's tick/service; arbitration sees the updated value.
  always_comb begin : p_pend
    pend_d = pend_q;
    if (tick && !serve && (pend_q != 2'd3)) begin
      pend_d = pend_q + 2'd1;
    end else if (serve && !tick) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_comb begin : p_arb
    winner = OwnIdle;
    if (pend_d == 2'd3) begin
      winner = OwnRef;
`ifdef CPU_FAIR_EN
    end else if (cpu_ok && (streak_q >= 2'd2)) begin
      winner = OwnCpu;
`endif
    end else if (VID_REQ) begin
      winner = OwnVid;
    end else if (cpu_ok) begin
      winner = OwnCpu;
    end else if (pend_d != 2'd0) begin
      winner = OwnRef;
    end
  end

`ifdef CPU_FAIR_EN
  always_comb begin : p_streak
    streak_d = streak_q;
    if (boundary) begin
      if ((winner == OwnCpu) || (winner == OwnIdle)) begin
        streak_d = 2'd0;
      end else if ((winner == OwnVid) && cpu_ok && (streak_q != 2'd3)) begin
        streak_d = streak_q + 2'd1;
      end
    end
  end
`endif

  always_comb begin : p_next
    sc_d      = boundary ? '0 : sc_q + ScW'(1);
    owner_d   = owner_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_d      = wr_q;
    byte_d    = byte_q;
    lane_d    = lane_q;
    ref_row_d = ref_row_q;
    div_d     = div_q;
    live_d    = live_q;
    gnt_d     = gnt_q;

    if (boundary) begin
      owner_d = winner;
      div_d   = tick ? '0 : div_q + DivW'(1);
      if (winner == OwnVid) begin
        row_d = ROW_BITS'(VID_ADDR[13:7]);
        col_d = ROW_BITS'(VID_ADDR[6:0]);
      end else if (winner == OwnCpu) begin
        row_d  = ROW_BITS'(CPU_ADDR[14:8]);
        col_d  = ROW_BITS'(CPU_ADDR[7:1]);
        wr_d   = CPU_WR;
        byte_d = CPU_BYTE;
        lane_d = CPU_ADDR[0];
      end
    end

    if ((owner_q == OwnRef) && (sc_d == ScLast)) begin
      ref_row_d = ref_row_q + ROW_BITS'(1);
    end

    // live tracks that CPU_REQ never dropped since this CPU slot was won
    if (boundary && (winner == OwnCpu)) begin
      live_d = 1'b1;
    end else if (!CPU_REQ) begin
      live_d = 1'b0;
    end

    if (gnt_q) begin
      gnt_d = CPU_REQ;
    end else begin
      gnt_d = CPU_REQ && live_q && (owner_q == OwnCpu) && (sc_d == PhLastOn);
    end
  end

  // Strobes are registered from the next phase so pins change cleanly on the edge.
  always_comb begin : p_out
    ra_d      = ra_q;
    nras_d    = 1'b1;
    ncas_d    = 2'b11;
    nwe_d     = 1'b1;
    vid_ack_d = 1'b0;

    if ((owner_q == OwnRef) && (sc_d == PhRow)) begin
      ra_d = ref_row_q;
    end else if (data_slot && (sc_d == PhRow)) begin
      ra_d = row_q;
    end else if (data_slot && (sc_d == PhCol)) begin
      ra_d = col_q;
    end

    if ((owner_q != OwnIdle) && (sc_d >= PhRasOn) && (sc_d <= PhLastOn)) begin
      nras_d = 1'b0;
    end

    if (data_slot && (sc_d >= PhCasOn) && (sc_d <= PhLastOn)) begin
      if ((owner_q == OwnCpu) && wr_q && byte_q) begin
        ncas_d = lane_q ? 2'b01 : 2'b10;
      end else begin
        ncas_d = 2'b00;
      end
    end

    if ((owner_q == OwnCpu) && wr_q && (sc_d >= PhCol) && (sc_d <= PhLastOn)) begin
      nwe_d = 1'b0;
    end

    vid_ack_d = (owner_q == OwnVid) && (sc_d == PhLastOn);
  end

  always_ff @(posedge CLKIN or posedge RESET) begin : p_regs
    if (RESET) begin
      sc_q      <= '0;
      owner_q   <= OwnIdle;
      row_q     <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= 1'b0;
      ref_row_q <= '0;
      pend_q    <= 2'd0;
      div_q     <= '0;
      gnt_q     <= 1'b0;
      live_q    <= 1'b0;
      ra_q      <= '0;
      nras_q    <= 1'b1;
      ncas_q    <= 2'b11;
      nwe_q     <= 1'b1;
      vid_ack_q <= 1'b0;
`ifdef CPU_FAIR_EN
      streak_q  <= 2'd0;
`endif
    end else begin
      sc_q      <= sc_d;
      owner_q   <= owner_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_q      <= wr_d;
      byte_q    <= byte_d;
      lane_q    <= lane_d;
      ref_row_q <= ref_row_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      gnt_q     <= gnt_d;
      live_q    <= live_d;
      ra_q      <= ra_d;
      nras_q    <= nras_d;
      ncas_q    <= ncas_d;
      nwe_q     <= nwe_d;
      vid_ack_q <= vid_ack_d;
`ifdef CPU_FAIR_EN
      streak_q  <= streak_d;
`endif
    end
  end

  assign RA      = ra_q;
  assign nRAS    = nras_q;
  assign nCAS    = ncas_q;
  assign nWE     = nwe_q;
  assign VID_ACK = vid_ack_q;
  assign CPU_GNT = gnt_q;
  assign OWNER   = owner_q;

endmodule

// File: tb/tb_dram_slot_arbiter.sv
// Bench for dram_slot_arbiter: slot-level reference model checked every cycle, plus
// directed literal checks for addressing, strobes, refresh stepping and starvation.

module tb_dram_slot_arbiter;

  localparam int unsigned Div = 2;

  logic        CLKIN;
  logic        RESET;
  logic        VID_REQ;
  logic [13:0] VID_ADDR;
  logic        VID_ACK;
  logic        CPU_REQ;
  logic        CPU_WR;
  logic        CPU_BYTE;
  logic [14:0] CPU_ADDR;
  logic        CPU_GNT;
  logic [6:0]  RA;
  logic        nRAS;
  logic [1:0]  nCAS;
  logic        nWE;
  logic [1:0]  OWNER;

  int checks = 0;
  int errors = 0;
  int k = 0;

  dram_slot_arbiter #(
    .SLOT_LEN   (8),
    .REFRESH_DIV(Div),
    .ROW_BITS   (7)
  ) dut (
    .CLKIN   (CLKIN),
    .RESET   (RESET),
    .VID_REQ (VID_REQ),
    .VID_ADDR(VID_ADDR),
    .VID_ACK (VID_ACK),
    .CPU_REQ (CPU_REQ),
    .CPU_WR  (CPU_WR),
    .CPU_BYTE(CPU_BYTE),
    .CPU_ADDR(CPU_ADDR),
    .CPU_GNT (CPU_GNT),
    .RA      (RA),
    .nRAS    (nRAS),
    .nCAS    (nCAS),
    .nWE     (nWE),
    .OWNER   (OWNER)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot-level view of the arbiter (phase 0..7, owner 0..3).
  int m_ph, m_owner, m_pend, m_bnd, m_refrow, m_streak, m_ra, m_row, m_col;
  bit m_gnt, m_live, m_wr, m_byte, m_lane;

  initial begin : model
    int np, w, ec;
    bit tk, sv, cok, gnt_new, dslot;
    forever begin
      @(posedge CLKIN);
      if (RESET) begin
        m_ph = 0; m_owner = 0; m_pend = 0; m_bnd = 0; m_refrow = 0; m_streak = 0;
        m_ra = 0; m_row = 0; m_col = 0;
        m_gnt = 0; m_live = 0; m_wr = 0; m_byte = 0; m_lane = 0;
      end else begin
        np = (m_ph + 1) % 8;
        gnt_new = m_gnt ? CPU_REQ : (CPU_REQ && m_live && m_owner == 2 && np == 6);
        if (m_ph == 7) begin
          m_bnd++;
          tk = (m_bnd % Div) == 0;
          sv = (m_owner == 3);
          if (sv) m_refrow = (m_refrow + 1) % 128;
          if (tk && !sv) m_pend = (m_pend < 3) ? m_pend + 1 : 3;
          else if (sv && !tk) m_pend = m_pend - 1;
          cok = CPU_REQ && !m_gnt;
          if (m_pend == 3) w = 3;
`ifdef CPU_FAIR_EN
          else if (cok && m_streak >= 2) w = 2;
`endif
          else if (VID_REQ) w = 1;
          else if (cok) w = 2;
          else if (m_pend > 0) w = 3;
          else w = 0;
          if (w == 2 || w == 0) m_streak = 0;
          else if (w == 1 && cok && m_streak < 3) m_streak++;
          if (w == 1) begin
            m_row = int'(VID_ADDR) / 128;
            m_col = int'(VID_ADDR) % 128;
          end else if (w == 2) begin
            m_row = int'(CPU_ADDR) / 256;
            m_col = (int'(CPU_ADDR) / 2) % 128;
            m_wr = CPU_WR; m_byte = CPU_BYTE; m_lane = CPU_ADDR[0];
          end
          if (w == 2) m_live = 1;
          else if (!CPU_REQ) m_live = 0;
          m_owner = w;
        end else if (!CPU_REQ) begin
          m_live = 0;
        end
        m_gnt = gnt_new;
        m_ph = np;
        dslot = (m_owner == 1 || m_owner == 2);
        if (np == 1 && m_owner == 3) m_ra = m_refrow;
        else if (np == 1 && dslot) m_ra = m_row;
        else if (np == 3 && dslot) m_ra = m_col;
      end
      #1;
      dslot = (m_owner == 1 || m_owner == 2);
      ec = 3;
      if (dslot && m_ph >= 4 && m_ph <= 6)
        ec = (m_owner == 2 && m_wr && m_byte) ? (m_lane ? 1 : 2) : 0;
      check("m_OWNER", OWNER, m_owner);
      check("m_RA", RA, m_ra);
      check("m_nRAS", nRAS, (m_owner != 0 && m_ph >= 2 && m_ph <= 6) ? 0 : 1);
      check("m_nCAS", nCAS, ec);
      check("m_nWE", nWE, (m_owner == 2 && m_wr && m_ph >= 3 && m_ph <= 6) ? 0 : 1);
      check("m_VID_ACK", VID_ACK, (m_owner == 1 && m_ph == 6) ? 1 : 0);
      check("m_CPU_GNT", CPU_GNT, m_gnt ? 1 : 0);
    end
  end

  task automatic step();
    @(negedge CLKIN);
    k++;
  endtask

  task automatic to_k(input int t);
    while (k < t) step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLKIN);
    RESET = 1'b0;
    k = 0;
  endtask

  initial begin : main
    int grants;
    RESET = 1'b1; VID_REQ = 0; VID_ADDR = '0; CPU_REQ = 0; CPU_WR = 0; CPU_BYTE = 0;
    CPU_ADDR = '0;
    repeat (3) @(negedge CLKIN);
    check("rst_nRAS", nRAS, 1);
    check("rst_nCAS", nCAS, 3);
    check("rst_nWE", nWE, 1);
    check("rst_RA", RA, 0);
    check("rst_OWNER", OWNER, 0);
    check("rst_GNT", CPU_GNT, 0);

    // Video fetch, refresh, CPU byte write, refresh, then mid-slot reset.
    RESET = 1'b0; k = 0;
    VID_REQ = 1; VID_ADDR = 14'h2A55;
    to_k(8);  check("vid_owner", OWNER, 1);
    to_k(9);  check("vid_row", RA, 7'h54);
    to_k(11); check("vid_col", RA, 7'h55);
    to_k(12); check("vid_ncas", nCAS, 0);
    to_k(13); check("vid_ack_sc5", VID_ACK, 0);
    to_k(14); check("vid_ack_sc6", VID_ACK, 1);
    VID_REQ = 0;
    to_k(17); check("ref_owner0", OWNER, 3); check("ref_row0", RA, 0);
    to_k(18); check("ref_nras", nRAS, 0);
    to_k(20); check("ref_ncas", nCAS, 3);
    CPU_REQ = 1; CPU_WR = 1; CPU_BYTE = 1; CPU_ADDR = 15'h1235;
    to_k(24); check("cpu_owner", OWNER, 2);
    to_k(25); check("cpu_row", RA, 7'h12);
    to_k(27); check("cpu_col", RA, 7'h1A); check("cpu_nwe", nWE, 0);
    to_k(28); check("cpu_ncas_lane1", nCAS, 2'b01);
    to_k(29); check("cpu_gnt_sc5", CPU_GNT, 0);
    to_k(30); check("cpu_gnt_sc6", CPU_GNT, 1);
    to_k(33); check("ref_owner1", OWNER, 3); check("ref_row1", RA, 1);
    to_k(34); check("cpu_gnt_held", CPU_GNT, 1);
    CPU_REQ = 0;
    to_k(35); check("cpu_gnt_drop", CPU_GNT, 0);
    to_k(38); VID_REQ = 1;
    to_k(44); check("mid_ncas_pre", nCAS, 0); check("mid_owner_pre", OWNER, 1);
    #2 RESET = 1'b1;
    #1;
    check("mid_nRAS", nRAS, 1);
    check("mid_nCAS", nCAS, 3);
    check("mid_nWE", nWE, 1);
    check("mid_OWNER", OWNER, 0);
    VID_REQ = 0;
    repeat (2) @(negedge CLKIN);
    RESET = 1'b0; k = 0;

    // Refresh-only traffic: every second slot, rows 0..127 then wrap.
    for (int j = 0; j < 130; j++) begin
      to_k(8 * (2 + 2 * j) + 1);
      check("sweep_owner", OWNER, 3);
      check("sweep_row", RA, j % 128);
    end

    // Video and CPU both requesting continuously.
    do_reset();
    VID_REQ = 1; CPU_REQ = 1; CPU_WR = 0; CPU_BYTE = 0; CPU_ADDR = 15'($urandom);
    grants = 0;
    while (k < 8 * 48) begin
      step();
      if (k == 41) check("urgent_pre", OWNER, 1);
      if (k == 49) check("urgent_ref", OWNER, 3);
      if (CPU_GNT && CPU_REQ) begin
        grants++;
        CPU_REQ = 0;
      end else if (!CPU_GNT) begin
        CPU_REQ = 1;
      end
    end
`ifdef CPU_FAIR_EN
    check("fair_grants", (grants >= 4) ? 1 : 0, 1);
`else
    check("starve_grants", grants, 0);
`endif

    // Randomised traffic checked by the model, with one asynchronous reset.
    do_reset();
    VID_REQ = 0; CPU_REQ = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 15) == 0) VID_REQ = ~VID_REQ;
      VID_ADDR = 14'($urandom);
      if (!CPU_REQ) begin
        if (!CPU_GNT && $urandom_range(0, 5) == 0) begin
          CPU_REQ = 1; CPU_WR = 1'($urandom); CPU_BYTE = 1'($urandom);
          CPU_ADDR = 15'($urandom);
        end
      end else if (CPU_GNT) begin
        if ($urandom_range(0, 2) == 0) CPU_REQ = 0;
      end else if ($urandom_range(0, 60) == 0) begin
        CPU_REQ = 0;
      end
      if (i == 1500) begin
        #3 RESET = 1'b1;
        @(negedge CLKIN);
        RESET = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
